// File: rtl/out_ser_pkg.sv
// out_ser_pkg: shared definitions for the result-word serializer.
//   ser_state_e : serializer FSM states
//   FRAME_BITS  : bits per serial frame (start + data + parity + stop)
//   DATA_BITS   : payload bits per frame (matches datapath result width)
package out_ser_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } ser_state_e;

    localparam int DATA_BITS  = 11;
    localparam int FRAME_BITS = DATA_BITS + 3;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/wdata_i: write request and data (ignored when full)
//   pop_i/rdata_o : read request and current head word (pop ignored when empty)
//   full_o, empty_o, level_o : status derived from the registered pointers
// DEPTH must be a power of two and at least 2.
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bits means the write pointer has lapped the read pointer.
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign level_o = wr_q - rd_q;
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: contents are only visible through valid pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/out_serializer.sv
// out_serializer: buffers result words and sends each as a serial frame:
// start(0), DATA_W data bits LSB-first, even parity, stop(1); every bit
// lasts CLKS_PER_BIT clocks. tx idles high.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   in_valid  : producer offers in_data
//   in_data   : result word
//   in_ready  : FIFO not full
//   tx        : serial line (registered)
//   busy      : frame in progress (registered)
//   overflow  : one-cycle pulse after a word is offered while full (dropped)
//   level     : FIFO occupancy
//   state_dbg : current FSM state
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on registered FIFO state, so a word offered while
// full is dropped even if the FSM pops on that same edge.
module out_serializer
    import out_ser_pkg::*;
#(
    parameter int DATA_W       = DATA_BITS,
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       tx,
    output logic                       busy,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output ser_state_e                 state_dbg
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_W);

    ser_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] shift_q;
    logic              parity_q;
    logic              tx_q;
    logic              busy_q;
    logic              overflow_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              push;
    logic              pop;
    logic              bit_end;

    assign push    = in_valid && !fifo_full;
    assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    // Pop from IDLE, or on the last STOP edge so the next start bit follows with no gap.
    assign pop     = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .wdata_i (in_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    // tx is loaded with the value of the bit period being entered, so it is glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= in_valid && fifo_full;
            if (pop) begin
                state_q  <= START;
                cnt_q    <= '0;
                idx_q    <= '0;
                shift_q  <= fifo_rdata;
                parity_q <= ^fifo_rdata;
                tx_q     <= 1'b0;
                busy_q   <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        tx_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end
                    START: begin
                        if (bit_end) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                            tx_q    <= shift_q[0];
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            cnt_q <= '0;
                            if (idx_q == IDX_W'(DATA_W - 1)) begin
                                state_q <= PARITY;
                                idx_q   <= '0;
                                tx_q    <= parity_q;
                            end else begin
                                idx_q   <= idx_q + IDX_W'(1);
                                shift_q <= shift_q >> 1;
                                tx_q    <= shift_q[1];
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state_q <= STOP;
                            cnt_q   <= '0;
                            tx_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    STOP: begin
                        // Reaching the end here means the FIFO was empty (pop handled above).
                        if (bit_end) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready  = !fifo_full;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_out_serializer.sv
// Bench for out_serializer. The reference model keeps the FIFO as a queue of
// words and the frame in flight as a queue of expected per-cycle tx values.
module tb_out_serializer;
    import out_ser_pkg::*;

    localparam int DATA_W = 11;
    localparam int DEPTH  = 4;
    localparam int CPB    = 4;
    localparam int LVL_W  = $clog2(DEPTH + 1);

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data  = '0;
    logic              in_ready;
    logic              tx;
    logic              busy;
    logic              overflow;
    logic [LVL_W-1:0]  level;
    ser_state_e        state_dbg;

    always #5 clk = ~clk;

    out_serializer #(
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .tx        (tx),
        .busy      (busy),
        .overflow  (overflow),
        .level     (level),
        .state_dbg (state_dbg)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] exp_q[$];   // model FIFO contents
    logic              line_q[$];  // expected tx per remaining cycle of current frame
    logic              exp_ovf = 1'b0;

    // per-test observations
    logic cap_q[$];
    int   bsy_cycles;
    int   bsy_runs;
    int   ovf_seen;
    logic prev_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_frame(input logic [DATA_W-1:0] w);
        logic b;
        for (int k = 0; k < FRAME_BITS; k++) begin
            if (k == 0)                b = 1'b0;
            else if (k <= DATA_W)      b = w[k-1];
            else if (k == DATA_W + 1)  b = ^w;
            else                       b = 1'b1;
            for (int c = 0; c < CPB; c++) line_q.push_back(b);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        line_q.delete();
        exp_ovf = 1'b0;
    endtask

    // Advance the model by one rising edge, using the inputs present at that edge.
    task automatic model_edge();
        int sz;
        sz = exp_q.size();
        if (!rst) begin
            model_reset();
            return;
        end
        exp_ovf = in_valid && (sz == DEPTH);
        if (line_q.size() > 0) void'(line_q.pop_front());
        if ((line_q.size() == 0) && (sz > 0)) load_frame(exp_q.pop_front());
        if (in_valid && (sz < DEPTH)) exp_q.push_back(in_data);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".tx"},       tx,       (line_q.size() > 0) ? line_q[0] : 1'b1);
        check({tag, ".busy"},     busy,     line_q.size() > 0);
        check({tag, ".level"},    level,    exp_q.size());
        check({tag, ".in_ready"}, in_ready, exp_q.size() < DEPTH);
        check({tag, ".overflow"}, overflow, exp_ovf);
    endtask

    task automatic clear_obs();
        cap_q.delete();
        bsy_cycles = 0;
        bsy_runs   = 0;
        ovf_seen   = 0;
        prev_busy  = busy;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
        cap_q.push_back(tx);
        if (busy) begin
            bsy_cycles++;
            if (!prev_busy) bsy_runs++;
        end
        if (overflow) ovf_seen++;
        prev_busy = busy;
    endtask

    task automatic push_word(input string tag, input logic [DATA_W-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick(tag);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        logic drained;
        drained = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick(tag);
            if (!busy && (line_q.size() == 0) && (exp_q.size() == 0)) begin
                drained = 1'b1;
                break;
            end
        end
        check({tag, ".drained"}, drained, 1'b1);
    endtask

    // Mid-bit sample of frame slot k; the frame's first cycle is cap_q[first].
    function automatic logic slot(input int first, input int k);
        int idx;
        idx = first + k * CPB + 1;
        return (idx < cap_q.size()) ? cap_q[idx] : 1'bx;
    endfunction

    initial begin
        logic [FRAME_BITS-1:0] frame_obs;
        logic [FRAME_BITS-1:0] frame_5a3;
        int                    guard;
        int                    rate;

        // ---- power-up reset (asynchronous) ----
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("por.tx",       tx,       1'b1);
        check("por.busy",     busy,     1'b0);
        check("por.level",    level,    0);
        check("por.in_ready", in_ready, 1'b1);
        check("por.overflow", overflow, 1'b0);
        check("por.state",    state_dbg, IDLE);
        tick("por_hold");
        tick("por_hold");
        rst = 1'b1;
        repeat (3) tick("idle");

        // ---- single word 0x5A3 ----
        clear_obs();
        push_word("w5a3", 11'h5A3);
        wait_idle("w5a3", 200);
        for (int k = 0; k < FRAME_BITS; k++) frame_obs[k] = slot(1, k);
        frame_5a3 = 14'b10101101000110;  // slot 0 (start) is the LSB
        check("w5a3.frame", frame_obs, frame_5a3);
        check("w5a3.busy_cycles", bsy_cycles, 56);
        check("w5a3.busy_runs",   bsy_runs,   1);

        // ---- odd-weight word 0x001 ----
        clear_obs();
        push_word("w001", 11'h001);
        wait_idle("w001", 200);
        check("w001.parity", slot(1, DATA_W + 1), 1'b1);
        check("w001.idle_tx", tx, 1'b1);

        // ---- back-to-back, three words ----
        clear_obs();
        push_word("b2b", 11'h7FF);
        push_word("b2b", 11'h2C5);
        push_word("b2b", 11'h400);
        wait_idle("b2b", 400);
        check("b2b.busy_cycles", bsy_cycles, 168);
        check("b2b.busy_runs",   bsy_runs,   1);
        check("b2b.frame2_start", slot(1 + 56, 0), 1'b0);
        check("b2b.frame3_start", slot(1 + 112, 0), 1'b0);

        // ---- overflow: six pushes from idle ----
        clear_obs();
        push_word("ovf.w0", 11'h011);
        push_word("ovf.w1", 11'h122);
        check("ovf.w0_popped_busy",  busy,  1'b1);
        check("ovf.w0_popped_level", level, 1);
        push_word("ovf.w2", 11'h233);
        push_word("ovf.w3", 11'h344);
        push_word("ovf.w4", 11'h455);
        check("ovf.full_level",    level,    DEPTH);
        check("ovf.full_in_ready", in_ready, 1'b0);
        push_word("ovf.w5", 11'h566);
        check("ovf.pulse",        overflow, 1'b1);
        check("ovf.w5_in_ready",  in_ready, 1'b0);
        check("ovf.w5_level",     level,    DEPTH);
        tick("ovf.after");
        check("ovf.pulse_end",    overflow, 1'b0);
        wait_idle("ovf", 600);
        check("ovf.pulse_count",  ovf_seen,   1);
        check("ovf.busy_cycles",  bsy_cycles, 5 * 56);

        // ---- simultaneous push/pop at level 2 ----
        clear_obs();
        push_word("pp", 11'h0A5);
        push_word("pp", 11'h15A);
        push_word("pp", 11'h3C3);
        check("pp.level_pre", level, 2);
        guard = 0;
        while ((line_q.size() != 1) && (guard < 200)) begin
            tick("pp.wait");
            guard++;
        end
        check("pp.reached_stop_end", guard < 200, 1'b1);
        push_word("pp.edge", 11'h6E1);
        check("pp.level_post", level, 2);
        check("pp.start_bit",  tx,    1'b0);
        wait_idle("pp", 600);

        // ---- reset mid-frame ----
        push_word("rmf", 11'h1F0);
        repeat (20) tick("rmf.run");
        #3 rst = 1'b0;
        model_reset();
        #1;
        check("rmf.tx",       tx,       1'b1);
        check("rmf.busy",     busy,     1'b0);
        check("rmf.level",    level,    0);
        check("rmf.in_ready", in_ready, 1'b1);
        check("rmf.state",    state_dbg, IDLE);
        in_valid = 1'b1;
        in_data  = 11'h3AB;
        repeat (3) tick("rmf.hold");
        rst = 1'b1;
        in_data = 11'h2D4;
        tick("rmf.first_push");
        in_valid = 1'b0;
        check("rmf.first_push_level", level, 1);
        wait_idle("rmf", 200);

        // ---- randomized traffic ----
        for (int seg = 0; seg < 6; seg++) begin
            rate = (seg % 2 == 0) ? $urandom_range(2, 6) : $urandom_range(20, 60);
            for (int c = 0; c < 100; c++) begin
                in_valid = ($urandom_range(0, 99) < rate);
                in_data  = DATA_W'($urandom);
                tick("rnd");
            end
        end
        in_valid = 1'b0;
        wait_idle("rnd", 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
